// File: rtl/uart_loader_if.sv
// Byte-stream input from the UART receiver and the instruction-memory
// write port, bundled so the loader and its neighbours share one handle.
// The loader uses the slave modport; the byte source / memory side uses master.
interface uart_loader_if #(
   parameter int ADDR_WIDTH = 10
);
   logic [7:0]            rx_byte;
   logic                  rx_byte_valid;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;

   modport master (
      output rx_byte,
      output rx_byte_valid,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );

   modport slave (
      input  rx_byte,
      input  rx_byte_valid,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );
endinterface

// File: rtl/uart_loader.sv
// Program loader: turns the UART byte stream (MAGIC, 4-byte little-endian
// word count, N little-endian words, XOR checksum) into instruction-memory
// writes and keeps the CPU in reset until a load has been verified.
module uart_loader #(
   parameter int          ADDR_WIDTH    = 10,
   parameter int          TIMEOUT_CLKS  = 1000000,
   parameter logic [7:0]  MAGIC         = 8'hA5,
   parameter bit          HOLD_AT_RESET = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_loader_if.slave     bus,
   output logic             cpu_hold,
   output logic             busy,
   output logic             load_done,
   output logic             load_error
);

   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam int WW = ADDR_WIDTH + 1;

   // Largest legal word count: exactly fills the memory.
   localparam logic [32:0]   CAPACITY = 33'd1 << ADDR_WIDTH;
   // Counter value on the last idle clock before the load is abandoned.
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CHECK,
      S_ERROR
   } state_t;

   state_t          state_reg;
   logic [1:0]      byte_idx_reg;
   logic [WW-1:0]   word_idx_reg;
   logic [31:0]     len_reg;
   logic [31:0]     word_reg;
   logic [7:0]      csum_reg;
   logic [TW-1:0]   tmo_reg;

   logic [31:0]     len_full;
   logic [31:0]     word_full;
   logic [7:0]      csum_next;
   logic [WW-1:0]   word_idx_next;
   logic            len_oversize;
   logic            last_word;
   logic            load_active;
   logic            tmo_expire;

   // Length bytes arrive LSB first, so each new byte enters at the top.
   assign len_full      = {bus.rx_byte, len_reg[31:8]};
   assign len_oversize  = ({1'b0, len_full} > CAPACITY);
   assign csum_next     = csum_reg ^ bus.rx_byte;
   assign word_idx_next = word_idx_reg + 1'b1;
   assign last_word     = (32'(word_idx_next) == len_reg);
   assign load_active   = (state_reg == S_LEN) || (state_reg == S_DATA) ||
                          (state_reg == S_CHECK);
   assign tmo_expire    = (tmo_reg == TMO_LAST);

   // Word being assembled with the incoming byte dropped into its lane.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign word_full[gi*8 +: 8] = (byte_idx_reg == 2'(gi)) ?
                                       bus.rx_byte : word_reg[gi*8 +: 8];
      end
   endgenerate

   // Load sequencer: protocol FSM, counters, checksum and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         byte_idx_reg   <= '0;
         word_idx_reg   <= '0;
         len_reg        <= '0;
         word_reg       <= '0;
         csum_reg       <= '0;
         tmo_reg        <= '0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         cpu_hold       <= HOLD_AT_RESET;
         busy           <= 1'b0;
         load_done      <= 1'b0;
         load_error     <= 1'b0;
      end else begin
         bus.imem_we <= 1'b0;

         // Inter-byte watchdog; a byte arriving on the expiry clock still wins.
         if (load_active) begin
            if (bus.rx_byte_valid) begin
               tmo_reg <= '0;
            end else begin
               tmo_reg <= tmo_reg + 1'b1;
               if (tmo_expire) begin
                  state_reg  <= S_ERROR;
                  load_error <= 1'b1;
                  busy       <= 1'b0;
               end
            end
         end

         case (state_reg)
            S_IDLE: begin
               if (bus.rx_byte_valid && (bus.rx_byte == MAGIC)) begin
                  state_reg    <= S_LEN;
                  busy         <= 1'b1;
                  cpu_hold     <= 1'b1;
                  load_done    <= 1'b0;
                  load_error   <= 1'b0;
                  byte_idx_reg <= '0;
                  word_idx_reg <= '0;
                  len_reg      <= '0;
                  word_reg     <= '0;
                  csum_reg     <= '0;
                  tmo_reg      <= '0;
               end
            end

            S_LEN: begin
               if (bus.rx_byte_valid) begin
                  len_reg      <= len_full;
                  csum_reg     <= csum_next;
                  byte_idx_reg <= byte_idx_reg + 2'd1;
                  if (byte_idx_reg == 2'd3) begin
                     if (len_oversize) begin
                        state_reg  <= S_ERROR;
                        load_error <= 1'b1;
                        busy       <= 1'b0;
                     end else if (len_full == 32'd0) begin
                        state_reg <= S_CHECK;
                     end else begin
                        state_reg <= S_DATA;
                     end
                  end
               end
            end

            S_DATA: begin
               if (bus.rx_byte_valid) begin
                  word_reg     <= word_full;
                  csum_reg     <= csum_next;
                  byte_idx_reg <= byte_idx_reg + 2'd1;
                  if (byte_idx_reg == 2'd3) begin
                     // Word complete: one-cycle write strobe on the next clock.
                     bus.imem_we    <= 1'b1;
                     bus.imem_addr  <= word_idx_reg[ADDR_WIDTH-1:0];
                     bus.imem_wdata <= word_full;
                     word_idx_reg   <= word_idx_next;
                     if (last_word) begin
                        state_reg <= S_CHECK;
                     end
                  end
               end
            end

            S_CHECK: begin
               if (bus.rx_byte_valid) begin
                  if (bus.rx_byte == csum_reg) begin
                     state_reg <= S_IDLE;
                     load_done <= 1'b1;
                     busy      <= 1'b0;
                     cpu_hold  <= 1'b0;
                  end else begin
                     state_reg  <= S_ERROR;
                     load_error <= 1'b1;
                     busy       <= 1'b0;
                  end
               end
            end

            // Failed load: flags were set on entry; CPU stays held.
            S_ERROR: begin
               state_reg <= S_IDLE;
            end

            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed protocol cases plus
// randomized loads scored against a byte-stream reference model.
module tb_uart_loader;

   localparam int         AW    = 10;
   localparam int         TMO   = 50;
   localparam logic [7:0] MAGIC = 8'hA5;

   localparam int RES_NONE = 0;
   localparam int RES_DONE = 1;
   localparam int RES_ERR  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic cpu_hold;
   logic busy;
   logic load_done;
   logic load_error;

   uart_loader_if #(.ADDR_WIDTH(AW)) bus ();

   uart_loader #(
      .ADDR_WIDTH    (AW),
      .TIMEOUT_CLKS  (TMO),
      .MAGIC         (MAGIC),
      .HOLD_AT_RESET (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Single comparison point for the whole bench.
   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory-write monitor.
   logic [AW-1:0] wr_addr_q[$];
   logic [31:0]   wr_data_q[$];

   always @(posedge clk) begin
      #1;
      if (bus.imem_we === 1'b1) begin
         wr_addr_q.push_back(bus.imem_addr);
         wr_data_q.push_back(bus.imem_wdata);
      end
   end

   // Reference model: derive writes and outcome from the byte stream.
   logic [7:0]    stream_q[$];
   logic [AW-1:0] exp_addr_q[$];
   logic [31:0]   exp_data_q[$];
   int            exp_result;

   task automatic model_stream();
      int         m;
      int         b;
      logic [31:0] len;
      logic [7:0]  chk;
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_result = RES_NONE;
      m = -1;
      for (int i = 0; i < stream_q.size(); i++)
         if (m < 0 && stream_q[i] == MAGIC) m = i;
      if (m < 0 || stream_q.size() < m + 5) return;
      len = {stream_q[m+4], stream_q[m+3], stream_q[m+2], stream_q[m+1]};
      chk = stream_q[m+1] ^ stream_q[m+2] ^ stream_q[m+3] ^ stream_q[m+4];
      if (len > (32'd1 << AW)) begin
         exp_result = RES_ERR;
         return;
      end
      for (int w = 0; w < int'(len); w++) begin
         b = m + 5 + 4 * w;
         exp_addr_q.push_back(AW'(w));
         exp_data_q.push_back({stream_q[b+3], stream_q[b+2], stream_q[b+1], stream_q[b]});
         chk = chk ^ stream_q[b] ^ stream_q[b+1] ^ stream_q[b+2] ^ stream_q[b+3];
      end
      b = m + 5 + 4 * int'(len);
      if (stream_q.size() <= b) return;
      exp_result = (stream_q[b] == chk) ? RES_DONE : RES_ERR;
   endtask

   // One byte strobe; returns 1 time unit after the sampling edge.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_byte       = b;
      bus.rx_byte_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_byte_valid = 1'b0;
   endtask

   // Random well-formed load (optionally with a corrupted checksum).
   task automatic build_load(input int n_words, input bit corrupt, input int garbage);
      logic [7:0]  b;
      logic [7:0]  cks;
      logic [31:0] n;
      stream_q.delete();
      for (int g = 0; g < garbage; g++) begin
         do b = 8'($urandom); while (b == MAGIC);
         stream_q.push_back(b);
      end
      stream_q.push_back(MAGIC);
      n   = 32'(n_words);
      cks = 8'h00;
      for (int k = 0; k < 4; k++) begin
         b = n[8*k +: 8];
         stream_q.push_back(b);
         cks = cks ^ b;
      end
      for (int k = 0; k < 4 * n_words; k++) begin
         b = 8'($urandom);
         stream_q.push_back(b);
         cks = cks ^ b;
      end
      if (corrupt) cks = cks ^ 8'($urandom_range(255, 1));
      stream_q.push_back(cks);
   endtask

   // Send stream_q, then score writes and status flags against the model.
   task automatic run_stream(input string name, input int max_gap, input int long_gap_at);
      int gap;
      model_stream();
      wr_addr_q.delete();
      wr_data_q.delete();
      for (int i = 0; i < stream_q.size(); i++) begin
         if (i == long_gap_at)  gap = TMO - 1;
         else if (i == 0)       gap = 0;
         else                   gap = $urandom_range(max_gap, 0);
         repeat (gap) @(posedge clk);
         send_byte(stream_q[i]);
      end
      check_eq({name, ".done"},  32'(load_done),  32'(exp_result == RES_DONE));
      check_eq({name, ".error"}, 32'(load_error), 32'(exp_result == RES_ERR));
      check_eq({name, ".hold"},  32'(cpu_hold),   32'(exp_result != RES_DONE));
      check_eq({name, ".busy"},  32'(busy),       32'd0);
      check_eq({name, ".nwr"},   32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
      for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
         check_eq({name, ".addr"}, 32'(wr_addr_q[i]), 32'(exp_addr_q[i]));
         check_eq({name, ".data"}, wr_data_q[i], exp_data_q[i]);
      end
      $display("load %s: %0d bytes, %0d writes, done=%0b error=%0b hold=%0b",
               name, stream_q.size(), wr_addr_q.size(), load_done, load_error, cpu_hold);
      repeat (3) @(posedge clk);
   endtask

   initial begin
      bus.rx_byte       = 8'h00;
      bus.rx_byte_valid = 1'b0;

      // Reset values while rst_n is held low.
      repeat (2) @(negedge clk);
      check_eq("rst.we",    32'(bus.imem_we),    32'd0);
      check_eq("rst.addr",  32'(bus.imem_addr),  32'd0);
      check_eq("rst.wdata", bus.imem_wdata,      32'd0);
      check_eq("rst.hold",  32'(cpu_hold),       32'd1);
      check_eq("rst.busy",  32'(busy),           32'd0);
      check_eq("rst.done",  32'(load_done),      32'd0);
      check_eq("rst.error", 32'(load_error),     32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Garbage in IDLE is ignored.
      wr_addr_q.delete();
      send_byte(8'h00);
      send_byte(8'hFF);
      repeat (2) @(posedge clk);
      #1;
      check_eq("garbage.busy", 32'(busy), 32'd0);
      check_eq("garbage.hold", 32'(cpu_hold), 32'd1);
      check_eq("garbage.nwr",  32'(wr_addr_q.size()), 32'd0);
      $display("load garbage: 2 bytes ignored");

      // Directed loads, back-to-back strobes.
      stream_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
      run_stream("good", 0, -1);
      stream_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h6F, 8'h00, 8'h00, 8'h00, 8'h00};
      run_stream("badcks", 0, -1);
      stream_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_stream("zero", 0, -1);
      stream_q = '{8'hA5, 8'h01, 8'h04, 8'h00, 8'h00};
      run_stream("oversize", 0, -1);

      // Timeout: silence after a partial word.
      wr_addr_q.delete();
      stream_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
      foreach (stream_q[i]) send_byte(stream_q[i]);
      repeat (TMO - 1) @(posedge clk);
      #1;
      check_eq("tmo.early_error", 32'(load_error), 32'd0);
      check_eq("tmo.early_busy",  32'(busy),       32'd1);
      @(posedge clk);
      #1;
      check_eq("tmo.error", 32'(load_error), 32'd1);
      check_eq("tmo.busy",  32'(busy),       32'd0);
      check_eq("tmo.hold",  32'(cpu_hold),   32'd1);
      check_eq("tmo.nwr",   32'(wr_addr_q.size()), 32'd0);
      $display("load timeout: error=%0b after %0d idle clocks", load_error, TMO);
      repeat (3) @(posedge clk);
      build_load(3, 1'b0, 0);
      run_stream("after_tmo", 2, -1);

      // A byte on the expiry clock keeps the load alive.
      build_load(2, 1'b0, 0);
      run_stream("byte_wins", 1, 7);

      // Asynchronous reset in the middle of a load, on a write strobe.
      stream_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      foreach (stream_q[i]) send_byte(stream_q[i]);
      check_eq("midrst.we_before", 32'(bus.imem_we), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("midrst.we",    32'(bus.imem_we),   32'd0);
      check_eq("midrst.addr",  32'(bus.imem_addr), 32'd0);
      check_eq("midrst.wdata", bus.imem_wdata,     32'd0);
      check_eq("midrst.hold",  32'(cpu_hold),      32'd1);
      check_eq("midrst.busy",  32'(busy),          32'd0);
      check_eq("midrst.done",  32'(load_done),     32'd0);
      check_eq("midrst.error", 32'(load_error),    32'd0);
      $display("load midrst: reset asserted during DATA");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      build_load(4, 1'b0, 1);
      run_stream("after_rst", 0, -1);

      // Randomized loads with gaps, garbage prefixes and bad checksums.
      for (int t = 0; t < 20; t++) begin
         build_load($urandom_range(8, 0), ($urandom_range(3, 0) == 0),
                    $urandom_range(2, 0));
         run_stream($sformatf("rand%0d", t), 5, -1);
      end

      // Word count equal to capacity fills memory exactly.
      build_load(1 << AW, 1'b0, 0);
      run_stream("full", 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
